// File: rtl/swap_req_sched.sv
// Round-robin scheduler that shares one swap engine among NREQ requesters.
// Optional feature: define SWAP_SCHED_ALIAS_SKIP_EN to complete addra==addrb commands without the engine.
module swap_req_sched #(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int CW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_addra,
  input  logic [NREQ*AW-1:0] req_addrb,
  output logic [NREQ-1:0]   rsp_done,
  output logic              eng_start,
  output logic [AW-1:0]     eng_addra,
  output logic [AW-1:0]     eng_addrb,
  input  logic [1:0]        eng_state,
  output logic              busy,
  output logic [CW-1:0]     done_cnt
);

  // state    | meaning
  // S_IDLE   | waiting for an idle engine and a valid request
  // S_ISSUE  | holding eng_start until the engine enters SEND_READ
  // S_WAIT   | engine reading; waiting for SEND_WRITE
  // S_RESP   | rsp_done pulse to the owning requester
  localparam int GW = $clog2(NREQ);
  localparam logic [1:0] ENG_IDLE  = 2'd0;
  localparam logic [1:0] ENG_READ  = 2'd1;
  localparam logic [1:0] ENG_WRITE = 2'd2;
  localparam logic [1:0] ENG_BAD   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] gid;
  logic [GW-1:0] grant;
  logic [GW-1:0] idx;
  logic          grant_any;
  logic          accept;
  logic          alias_cmd;
  logic [AW-1:0] sel_addra;
  logic [AW-1:0] sel_addrb;

  // Search starts one past the last completed grant and wraps.
  always_comb begin
    grant_any = 1'b0;
    grant     = '0;
    idx       = last_grant;
    for (int k = 0; k < NREQ; k++) begin
      idx = (idx == GW'(NREQ - 1)) ? '0 : idx + 1'b1;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant     = idx;
      end
    end
  end

  always_comb begin
    sel_addra = '0;
    sel_addrb = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == GW'(i)) begin
        sel_addra = req_addra[i*AW +: AW];
        sel_addrb = req_addrb[i*AW +: AW];
      end
    end
  end

`ifdef SWAP_SCHED_ALIAS_SKIP_EN
  assign alias_cmd = (sel_addra == sel_addrb);
`else
  assign alias_cmd = 1'b0;
`endif

  assign accept    = (state == S_IDLE) && (eng_state == ENG_IDLE) && grant_any && !rst;
  assign req_ready = accept ? (NREQ'(1) << grant) : '0;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= GW'(NREQ - 1);
      gid        <= '0;
      rsp_done   <= '0;
      eng_start  <= 1'b0;
      eng_addra  <= '0;
      eng_addrb  <= '0;
      done_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            eng_addra <= sel_addra;
            eng_addrb <= sel_addrb;
            gid       <= grant;
            if (alias_cmd) begin
              rsp_done   <= req_ready;
              last_grant <= grant;
              done_cnt   <= done_cnt + CW'(1);
              state      <= S_RESP;
            end else begin
              eng_start <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (eng_state == ENG_READ) begin
            eng_start <= 1'b0;
            state     <= S_WAIT;
          end else if (eng_state == ENG_BAD) begin
            eng_start <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (eng_state == ENG_WRITE) begin
            rsp_done   <= NREQ'(1) << gid;
            last_grant <= gid;
            done_cnt   <= done_cnt + CW'(1);
            state      <= S_RESP;
          end else if (eng_state == ENG_BAD) begin
            state <= S_IDLE;
          end
        end
        S_RESP: begin
          rsp_done <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swap_req_sched.sv
// Directed testbench for swap_req_sched with a small behavioural swap engine.
module tb_swap_req_sched;
  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int CW   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*AW-1:0] req_addra;
  logic [NREQ*AW-1:0] req_addrb;
  logic [NREQ-1:0]   rsp_done;
  logic              eng_start;
  logic [AW-1:0]     eng_addra;
  logic [AW-1:0]     eng_addrb;
  logic [1:0]        eng_state;
  logic              busy;
  logic [CW-1:0]     done_cnt;

  logic [1:0] model_state;
  logic       ovr_en;
  logic [1:0] ovr_val;

  int tests  = 0;
  int failed = 0;

  swap_req_sched #(.NREQ(NREQ), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addra(req_addra), .req_addrb(req_addrb),
    .rsp_done(rsp_done),
    .eng_start(eng_start), .eng_addra(eng_addra), .eng_addrb(eng_addrb),
    .eng_state(eng_state),
    .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  // Engine: IDLE -start-> SEND_READ -> SEND_WRITE -> IDLE
  always @(posedge clk) begin
    if (rst) model_state <= 2'd0;
    else begin
      case (model_state)
        2'd0: if (eng_start) model_state <= 2'd1;
        2'd1: model_state <= 2'd2;
        default: model_state <= 2'd0;
      endcase
    end
  end
  assign eng_state = ovr_en ? ovr_val : model_state;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if ({req_ready, rsp_done, eng_start, busy} !== 6'b0) begin
      failed++;
      $display("FAIL reset_ctrl: got ready=%b done=%b start=%b busy=%b, want all 0", req_ready, rsp_done, eng_start, busy);
    end
    tests++;
    if (eng_addra !== 32'h0 || eng_addrb !== 32'h0 || done_cnt !== 4'd0) begin
      failed++;
      $display("FAIL reset_data: got addra=%h addrb=%h cnt=%0d, want 0", eng_addra, eng_addrb, done_cnt);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_addra = {32'h0, 32'h10};
    req_addrb = {32'h0, 32'h20};
    req_valid = 2'b01;
    #1;
    tests++;
    if (req_ready !== 2'b01) begin failed++; $display("FAIL single_ready: got %b want 01", req_ready); end
    cycle(); req_valid = 2'b00;
    tests++;
    if (eng_start !== 1'b1 || eng_addra !== 32'h10 || eng_addrb !== 32'h20 || busy !== 1'b1) begin
      failed++; $display("FAIL single_t1: got start=%b a=%h b=%h busy=%b want 1 10 20 1", eng_start, eng_addra, eng_addrb, busy);
    end
    cycle();
    tests++;
    if (eng_start !== 1'b1) begin failed++; $display("FAIL single_t2_start: got %b want 1", eng_start); end
    cycle();
    tests++;
    if (eng_start !== 1'b0 || rsp_done !== 2'b00) begin
      failed++; $display("FAIL single_t3: got start=%b done=%b want 0 00", eng_start, rsp_done);
    end
    cycle();
    tests++;
    if (rsp_done !== 2'b01) begin failed++; $display("FAIL single_t4_done: got %b want 01", rsp_done); end
    cycle();
    tests++;
    if (rsp_done !== 2'b00 || done_cnt !== 4'd1 || busy !== 1'b0) begin
      failed++; $display("FAIL single_t5: got done=%b cnt=%0d busy=%b want 00 1 0", rsp_done, done_cnt, busy);
    end
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] exp;
    logic [AW-1:0]   exp_a;
    do_reset();
    req_addra = {32'hB1, 32'hA1};
    req_addrb = {32'hB2, 32'hA2};
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp   = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (i % 2 == 0) ? 32'hA1 : 32'hB1;
      tests++;
      if (req_ready !== exp) begin failed++; $display("FAIL contention_ready[%0d]: got %b want %b", i, req_ready, exp); end
      cycle();
      tests++;
      if (eng_addra !== exp_a) begin failed++; $display("FAIL contention_addra[%0d]: got %h want %h", i, eng_addra, exp_a); end
      cycle(); cycle(); cycle();
      tests++;
      if (rsp_done !== exp) begin failed++; $display("FAIL contention_done[%0d]: got %b want %b", i, rsp_done, exp); end
      cycle();
    end
    req_valid = 2'b00;
    tests++;
    if (done_cnt !== 4'd4) begin failed++; $display("FAIL contention_cnt: got %0d want 4", done_cnt); end
  endtask

  task automatic test_engine_busy();
    do_reset();
    ovr_en = 1'b1; ovr_val = 2'd2;
    req_addra = {32'h0, 32'h33};
    req_addrb = {32'h0, 32'h44};
    req_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (req_ready !== 2'b00 || busy !== 1'b0) begin
        failed++; $display("FAIL engbusy_hold[%0d]: got ready=%b busy=%b want 00 0", i, req_ready, busy);
      end
      cycle();
    end
    ovr_en = 1'b0;
    #1;
    tests++;
    if (req_ready !== 2'b01) begin failed++; $display("FAIL engbusy_release: got %b want 01", req_ready); end
    cycle(); req_valid = 2'b00;
    cycle(); cycle(); cycle();
    tests++;
    if (rsp_done !== 2'b01) begin failed++; $display("FAIL engbusy_done: got %b want 01", rsp_done); end
    cycle();
  endtask

  task automatic test_reset_midop();
    do_reset();
    req_addra = {32'h2, 32'h1};
    req_addrb = {32'h4, 32'h3};
    req_valid = 2'b01;
    cycle(); req_valid = 2'b00;
    cycle(); cycle(); cycle(); cycle();
    req_valid = 2'b01;
    cycle(); req_valid = 2'b00;
    cycle(); cycle();
    tests++;
    if (busy !== 1'b1 || eng_start !== 1'b0) begin
      failed++; $display("FAIL midop_inwait: got busy=%b start=%b want 1 0", busy, eng_start);
    end
    rst = 1'b1;
    cycle();
    tests++;
    if (busy !== 1'b0 || eng_start !== 1'b0 || rsp_done !== 2'b00 || done_cnt !== 4'd0) begin
      failed++; $display("FAIL midop_after_rst: got busy=%b start=%b done=%b cnt=%0d want 0 0 00 0", busy, eng_start, rsp_done, done_cnt);
    end
    rst = 1'b0;
    req_valid = 2'b11;
    #1;
    tests++;
    if (req_ready !== 2'b01) begin failed++; $display("FAIL midop_regrant: got %b want 01", req_ready); end
    cycle(); req_valid = 2'b00;
    cycle(); cycle(); cycle(); cycle();
  endtask

  task automatic test_illegal();
    do_reset();
    req_addra = {32'h0, 32'h7};
    req_addrb = {32'h0, 32'h8};
    req_valid = 2'b01;
    cycle(); req_valid = 2'b00;
    ovr_en = 1'b1; ovr_val = 2'd3;
    cycle();
    ovr_en = 1'b0;
    tests++;
    if (busy !== 1'b0 || eng_start !== 1'b0) begin
      failed++; $display("FAIL illegal_drop: got busy=%b start=%b want 0 0", busy, eng_start);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rsp_done !== 2'b00 || done_cnt !== 4'd0) begin
        failed++; $display("FAIL illegal_quiet[%0d]: got done=%b cnt=%0d want 00 0", i, rsp_done, done_cnt);
      end
      cycle();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req_addra = {32'h0, 32'h100};
    req_addrb = {32'h0, 32'h200};
    req_valid = 2'b01;
    for (int i = 0; i < 75; i++) cycle();
    tests++;
    if (done_cnt !== 4'd15) begin failed++; $display("FAIL wrap_15: got %0d want 15", done_cnt); end
    for (int i = 0; i < 5; i++) cycle();
    tests++;
    if (done_cnt !== 4'd0) begin failed++; $display("FAIL wrap_0: got %0d want 0", done_cnt); end
    req_valid = 2'b00;
    cycle(); cycle(); cycle(); cycle(); cycle();
  endtask

  task automatic test_alias();
    do_reset();
    req_addra = {32'h0, 32'h5};
    req_addrb = {32'h0, 32'h5};
    req_valid = 2'b01;
    #1;
    tests++;
    if (req_ready !== 2'b01) begin failed++; $display("FAIL alias_ready: got %b want 01", req_ready); end
    cycle(); req_valid = 2'b00;
`ifdef SWAP_SCHED_ALIAS_SKIP_EN
    tests++;
    if (eng_start !== 1'b0 || rsp_done !== 2'b01) begin
      failed++; $display("FAIL alias_skip: got start=%b done=%b want 0 01", eng_start, rsp_done);
    end
    cycle();
`else
    tests++;
    if (eng_start !== 1'b1 || eng_addra !== 32'h5 || eng_addrb !== 32'h5) begin
      failed++; $display("FAIL alias_issue: got start=%b a=%h b=%h want 1 5 5", eng_start, eng_addra, eng_addrb);
    end
    cycle(); cycle(); cycle();
    tests++;
    if (rsp_done !== 2'b01) begin failed++; $display("FAIL alias_done: got %b want 01", rsp_done); end
    cycle();
`endif
    tests++;
    if (done_cnt !== 4'd1 || rsp_done !== 2'b00) begin
      failed++; $display("FAIL alias_cnt: got cnt=%0d done=%b want 1 00", done_cnt, rsp_done);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_addra = '0;
    req_addrb = '0;
    ovr_en = 1'b0;
    ovr_val = 2'd0;
    cycle();
    cycle();
    test_reset();
    rst = 1'b0;
    test_single();
    test_contention();
    test_engine_busy();
    test_reset_midop();
    test_illegal();
    test_wrap();
    test_alias();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "timeout");
  end

endmodule
